// File: rtl/extif_in_pktz_pkg.sv
// extif_in_pktz_pkg
// Shared definitions for the extif IN packetizer: FIFO entry width, FSM
// state encoding and a counter-width helper.
// Optional feature macro used by the importing files: EXTIF_IN_PKTZ_TIMER_EN.
package extif_in_pktz_pkg;

   // FIFO entry is {last, data[7:0]}
   localparam int ENTRY_W = 9;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_SIGNAL = 2'd3
   } state_e;

   // Bits needed to hold the values 0..n-1 (never less than 1).
   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/extif_in_pktz_fifo.sv
// extif_in_pktz_fifo
// Synchronous show-ahead FIFO, 2^AW entries of DW bits. The head entry is
// presented combinationally on rdata_o (forced to zero while empty).
// A push on a full FIFO is accepted when a pop happens in the same cycle.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   push_i, wdata_i  write request and data
//   pop_i            remove head entry
//   rdata_o          head entry
//   full_o, empty_o  current occupancy flags
//   full_nxt_o       FIFO will be full after this cycle
//   level_o          current occupancy (0..2^AW)
module extif_in_pktz_fifo
   import extif_in_pktz_pkg::*;
#(
   parameter int AW = 4,
   parameter int DW = ENTRY_W
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          full_nxt_o,
   output logic          empty_o,
   output logic [AW:0]   level_o
);

   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   level_q, level_d;
   logic          do_push, do_pop;

   assign empty_o    = (level_q == '0);
   assign full_o     = (level_q == FULL_LVL);
   assign do_pop     = pop_i & ~empty_o;
   assign do_push    = push_i & (~full_o | do_pop);
   assign level_d    = level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
   assign full_nxt_o = (level_d == FULL_LVL);
   assign level_o    = level_q;
   assign rdata_o    = empty_o ? '0 : mem_q[rptr_q];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         level_q <= level_d;
      end
   end

   // Storage carries data only; contents are meaningless until written.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/extif_in_pktz.sv
// extif_in_pktz
// User-side producer for the extif IN byte stream. User bytes are buffered
// in a show-ahead FIFO and offered to extif; an FSM raises flush hints that
// firmware polls to decide when to ship a partial USB packet.
// Optional feature: define EXTIF_IN_PKTZ_TIMER_EN to enable the idle timeout
// (idle_cnt and in_flush_time). Without it in_flush_time is tied low.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   u_data, u_last, u_valid, u_ready  user write side
//   u_flush                           one-cycle request to ship pending data
//   in_data, in_last, in_valid        FIFO head offered to extif
//   in_ready                          extif accepts the head byte
//   in_flush_now, in_flush_time       registered flush hints
//   fifo_level                        FIFO occupancy
module extif_in_pktz
   import extif_in_pktz_pkg::*;
#(
   parameter int FIFO_AW = 4,
   parameter int TIMEOUT = 1024,
   parameter int HOLD    = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       u_data,
   input  logic             u_last,
   input  logic             u_valid,
   output logic             u_ready,
   input  logic             u_flush,
   output logic [7:0]       in_data,
   output logic             in_last,
   output logic             in_valid,
   input  logic             in_ready,
   output logic             in_flush_now,
   output logic             in_flush_time,
   output logic [FIFO_AW:0] fifo_level
);

   localparam int HW = cnt_width(HOLD);

   logic [ENTRY_W-1:0] head;
   logic               push, pop, full, full_nxt, empty;
   logic               u_ready_q;
   state_e             state_q, state_d;
   logic               cause_q, cause_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic               seen_q, seen_d;
   logic               flush_now_q;

   assign push     = u_valid & u_ready_q & ~full;
   assign pop      = in_valid & in_ready;
   assign in_valid = ~empty;
   assign in_data  = head[7:0];
   assign in_last  = head[8];
   assign u_ready  = u_ready_q;

   extif_in_pktz_fifo #(.AW(FIFO_AW), .DW(ENTRY_W)) u_fifo (
      .clk_i      (clk),
      .rst_i      (rst),
      .push_i     (push),
      .wdata_i    ({u_last, u_data}),
      .pop_i      (pop),
      .rdata_o    (head),
      .full_o     (full),
      .full_nxt_o (full_nxt),
      .empty_o    (empty),
      .level_o    (fifo_level)
   );

`ifdef EXTIF_IN_PKTZ_TIMER_EN
   localparam int IW = cnt_width(TIMEOUT);
   logic [IW-1:0] idle_q, idle_d;
   logic          flush_time_q;
`endif

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      hold_d  = hold_q;
      seen_d  = seen_q;
`ifdef EXTIF_IN_PKTZ_TIMER_EN
      idle_d  = idle_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (u_flush) begin
               state_d = ST_DRAIN;
            end else if (pop && !in_last) begin
               state_d = ST_ARMED;
`ifdef EXTIF_IN_PKTZ_TIMER_EN
               idle_d  = '0;
`endif
            end
         end
         ST_ARMED: begin
            if (u_flush) begin
               state_d = ST_DRAIN;
            end else if (pop) begin
               if (in_last) state_d = ST_IDLE;
`ifdef EXTIF_IN_PKTZ_TIMER_EN
               idle_d = '0;
`endif
            end
`ifdef EXTIF_IN_PKTZ_TIMER_EN
            // Only count while extif has drained everything; a stalled
            // non-empty FIFO is not "idle".
            else if (empty) begin
               if (idle_q == IW'(TIMEOUT - 1)) begin
                  state_d = ST_SIGNAL;
                  cause_d = 1'b0;
                  hold_d  = '0;
                  seen_d  = 1'b0;
               end else begin
                  idle_d = idle_q + IW'(1);
               end
            end
`endif
         end
         ST_DRAIN: begin
            if (empty) begin
               state_d = ST_SIGNAL;
               cause_d = 1'b1;
               hold_d  = '0;
               seen_d  = 1'b0;
            end
         end
         ST_SIGNAL: begin
            // Remember unterminated traffic so the packet stays armed.
            if (pop && !in_last) seen_d = 1'b1;
            if (u_flush) begin
               cause_d = 1'b1;
               hold_d  = '0;
            end else if (hold_q == HW'(HOLD - 1)) begin
               state_d = seen_d ? ST_ARMED : ST_IDLE;
               hold_d  = '0;
`ifdef EXTIF_IN_PKTZ_TIMER_EN
               idle_d  = '0;
`endif
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cause_q     <= 1'b0;
         hold_q      <= '0;
         seen_q      <= 1'b0;
         u_ready_q   <= 1'b0;
         flush_now_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cause_q     <= cause_d;
         hold_q      <= hold_d;
         seen_q      <= seen_d;
         u_ready_q   <= ~full_nxt;
         flush_now_q <= (state_d == ST_SIGNAL) & cause_d;
      end
   end

   assign in_flush_now = flush_now_q;

`ifdef EXTIF_IN_PKTZ_TIMER_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_q       <= '0;
         flush_time_q <= 1'b0;
      end else begin
         idle_q       <= idle_d;
         flush_time_q <= (state_d == ST_SIGNAL) & ~cause_d;
      end
   end
   assign in_flush_time = flush_time_q;
`else
   assign in_flush_time = 1'b0;
`endif

endmodule
